// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector streaming controller and the
// multiplier core it drives: FSM state encoding and the derived latency and
// result-width helpers, so both sides compute the same values.
package matvec_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } mv_state_e;

    // Core pipeline depth: one multiplier register stage plus the adder tree.
    function automatic int mv_lat(input int c);
        return 1 + $clog2(c);
    endfunction

    // Exact width of a sum of c products of w_x by w_k signed operands.
    function automatic int mv_wy(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c);
    endfunction

    // Width of an index register covering 0..n-1 (never zero bits wide).
    function automatic int mv_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matvec_ser.sv
// Result serializer: captures the R-wide core result in one cycle and emits
// it element by element on a valid/ready stream, flagging the final element.
module matvec_ser
    import matvec_pkg::*;
#(
    parameter int R   = 8,
    parameter int W_Y = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [R*W_Y-1:0]      y_i,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_Y-1:0] m_data,
    output logic                  m_last
);

    localparam int RIDX_W = mv_idx_w(R);
    localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(R - 1);

    logic [R*W_Y-1:0]  y_q,     y_d;
    logic [RIDX_W-1:0] ridx_q,  ridx_d;
    logic              valid_q, valid_d;
    logic              hs;

    assign hs = valid_q && m_ready;

    // Next-state: parallel load wins, otherwise advance on each handshake.
    always_comb begin
        y_d     = y_q;
        ridx_d  = ridx_q;
        valid_d = valid_q;
        if (load_i) begin
            y_d     = y_i;
            ridx_d  = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            if (ridx_q == RIDX_LAST) begin
                ridx_d  = '0;
                valid_d = 1'b0;
            end else begin
                ridx_d = ridx_q + 1'b1;
            end
        end
    end

    // Buffer, read index and valid flag; reset discards buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            ridx_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            ridx_q  <= ridx_d;
            valid_q <= valid_d;
        end
    end

    // Outputs decode registered state only, so they hold under backpressure.
    always_comb begin
        m_valid = valid_q;
        m_data  = y_q[int'(ridx_q) * W_Y +: W_Y];
        m_last  = valid_q && (ridx_q == RIDX_LAST);
    end

endmodule

// File: rtl/matvec_stream_ctrl.sv
// Streaming front/back-end for the parallel pipelined matrix-vector core.
// LOAD assembles serial input elements into a C-wide vector, COMPUTE clocks
// the core for exactly its pipeline latency, DRAIN serializes the R results.
module matvec_stream_ctrl
    import matvec_pkg::*;
#(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int LAT = mv_lat(C),
    localparam int W_Y = mv_wy(W_X, W_K, C)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [W_X-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_Y-1:0] m_data,
    output logic                  m_last,
    output logic                  mv_cen,
    output logic [C*W_X-1:0]      mv_x,
    input  logic [R*W_Y-1:0]      mv_y,
    output logic                  err_len
);

    localparam int IDX_W = mv_idx_w(C);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C - 1);
    // cnt runs 0..LAT-1 with the core enabled, then LAT is the capture cycle.
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(LAT);

    mv_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [C*W_X-1:0]   x_q,     x_d;
    logic               err_q,   err_d;

    logic beat;
    logic close;
    logic cap;
    logic last_hs;
    logic ser_valid;
    logic ser_last;

    assign beat    = s_valid && s_ready;
    assign close   = (idx_q == IDX_LAST) || s_last;
    assign last_hs = ser_valid && m_ready && ser_last;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (beat && close)     state_d = COMPUTE;
            COMPUTE: if (cnt_q == CNT_CAP)  state_d = DRAIN;
            DRAIN:   if (last_hs)           state_d = LOAD;
            default:                        state_d = LOAD;
        endcase
    end

    // Moore outputs; s_ready is also forced low while reset is held.
    always_comb begin
        s_ready = 1'b0;
        mv_cen  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            LOAD:    s_ready = !rst;
            COMPUTE: begin
                mv_cen = (cnt_q != CNT_CAP);
                cap    = (cnt_q == CNT_CAP);
            end
            default: ;
        endcase
    end

    // Datapath next-state: element capture, beat/latency counters, length error.
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        x_d   = x_q;
        err_d = err_q;
        unique case (state_q)
            LOAD: begin
                if (beat) begin
                    x_d[int'(idx_q) * W_X +: W_X] = s_data;
                    idx_d = close ? '0 : idx_q + 1'b1;
                    cnt_d = '0;
                    // A full-length vector must carry its own last marker.
                    if ((idx_q == IDX_LAST) && !s_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            COMPUTE: cnt_d = cnt_q + 1'b1;
            DRAIN: begin
                // Short vectors rely on unwritten elements reading as zero.
                if (last_hs) begin
                    x_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any partial vector and the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
            x_q   <= '0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
            err_q <= err_d;
        end
    end

    assign mv_x    = x_q;
    assign err_len = err_q;
    assign m_valid = ser_valid;
    assign m_last  = ser_last;

    matvec_ser #(
        .R   (R),
        .W_Y (W_Y)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cap),
        .y_i     (mv_y),
        .m_valid (ser_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (ser_last)
    );

endmodule
